// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit XNOR LFSR (taps 15,12,5,1): generator step,
// lock-up value and checker state encoding.
package lfsr_pkg;

    localparam logic [15:0] LFSR16_TAPS   = 16'h9022;
    localparam logic [15:0] LFSR16_LOCKUP = 16'hFFFF;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

    // XNOR feedback: the all-ones state maps onto itself, all-zeros is a legal seed.
    function automatic logic lfsr16_fb(input logic [15:0] s);
        return ~^(s & LFSR16_TAPS);
    endfunction

    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {s[14:0], lfsr16_fb(s)};
    endfunction

endpackage

// File: rtl/lfsr_chk_window.sv
// Loss-of-lock window: counts checked bits and their errors over WINDOW bits and
// flags when the error count (including the current bit) reaches ERR_LIMIT.
module lfsr_chk_window
    import lfsr_pkg::*;
#(
    parameter int WINDOW    = 64,
    parameter int ERR_LIMIT = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic step_i,
    input  logic err_i,
    output logic limit_hit_o
);

    localparam int CW = $clog2(WINDOW + 1);

    logic [CW-1:0] bit_q;
    logic [CW-1:0] err_q;
    logic [CW-1:0] err_inc;
    logic          wrap;

    assign err_inc     = err_q + CW'(err_i);
    assign wrap        = (bit_q == CW'(WINDOW - 1));
    assign limit_hit_o = step_i && (err_inc >= CW'(ERR_LIMIT));

    // A limit hit and a window wrap both restart the statistics from zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_q <= '0;
            err_q <= '0;
        end else if (clear_i || (step_i && (limit_hit_o || wrap))) begin
            bit_q <= '0;
            err_q <= '0;
        end else if (step_i) begin
            bit_q <= bit_q + CW'(1);
            err_q <= err_inc;
        end
    end

endmodule

// File: rtl/lfsr_16bit_checker.sv
// Self-synchronising checker for the 16-bit XNOR LFSR stream: lock, error pulses,
// saturating error count. Define LFSR_CHECKER_BIT_CNT_EN to add bit_cnt_o.
module lfsr_16bit_checker
    import lfsr_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int WINDOW    = 64,
    parameter int ERR_LIMIT = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             valid_i,
    input  logic             data_i,
    output logic             locked_o,
    output logic             err_o,
    output logic             lost_o,
    output logic [CNT_W-1:0] err_cnt_o
`ifdef LFSR_CHECKER_BIT_CNT_EN
    ,
    output logic [31:0]      bit_cnt_o
`endif
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    chk_state_e       state_q, state_d;
    logic [15:0]      shift_q;
    logic [15:0]      shift_nx;
    logic [4:0]       fill_q, fill_d;
    logic             pred;
    logic             step;
    logic             mismatch;
    logic             limit_hit;
    logic             err_d, lost_d;
    logic             err_p1, lost_p1;
    logic [CNT_W-1:0] cnt_q;

    assign shift_nx = {shift_q[14:0], data_i};
    assign pred     = lfsr16_fb(shift_q);
    assign step     = valid_i && (state_q == LOCKED);

    lfsr_chk_window #(
        .WINDOW    (WINDOW),
        .ERR_LIMIT (ERR_LIMIT)
    ) u_window (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .step_i      (step),
        .err_i       (mismatch),
        .limit_hit_o (limit_hit)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SEARCH;
            fill_q  <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            if (valid_i) shift_q <= shift_nx;
        end
    end

    // Lock is judged on the register contents after the 16th bit has been shifted in.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        if (valid_i) begin
            case (state_q)
                SEARCH: begin
                    if (fill_q == 5'd15) begin
                        fill_d = '0;
                        if (shift_nx != LFSR16_LOCKUP) state_d = LOCKED;
                    end else begin
                        fill_d = fill_q + 5'd1;
                    end
                end
                LOCKED: begin
                    if (limit_hit) begin
                        state_d = SEARCH;
                        fill_d  = '0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_comb begin
        mismatch = step && (data_i != pred);
        err_d    = mismatch;
        lost_d   = step && limit_hit;
    end

    // ---- output stage: one cycle after the causing bit ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_p1  <= 1'b0;
            lost_p1 <= 1'b0;
            cnt_q   <= '0;
        end else begin
            err_p1  <= err_d;
            lost_p1 <= lost_d;
            if (clear_i)       cnt_q <= '0;
            else if (mismatch) cnt_q <= sat_inc(cnt_q);
        end
    end

    assign locked_o  = (state_q == LOCKED);
    assign err_o     = err_p1;
    assign lost_o    = lost_p1;
    assign err_cnt_o = cnt_q;

`ifdef LFSR_CHECKER_BIT_CNT_EN
    logic [31:0] bit_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                         bit_cnt_q <= '0;
        else if (clear_i)                    bit_cnt_q <= '0;
        else if (step && !(&bit_cnt_q))      bit_cnt_q <= bit_cnt_q + 32'd1;
    end

    assign bit_cnt_o = bit_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_16bit_checker.sv
// Randomised bench for lfsr_16bit_checker: two instances (default limits, and a
// 4-bit counter with ERR_LIMIT=WINDOW) checked against a bit-history reference model.
module tb_lfsr_16bit_checker;

    localparam int CW_A  = 16;
    localparam int CW_B  = 4;
    localparam int WIN   = 64;
    localparam int LIM_A = 8;
    localparam int LIM_B = 64;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic clear = 1'b0;
    logic valid = 1'b0;
    logic data = 1'b0;

    logic        locked_a, err_a, lost_a;
    logic        locked_b, err_b, lost_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
`ifdef LFSR_CHECKER_BIT_CNT_EN
    logic [31:0] bits_a, bits_b;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lfsr_16bit_checker #(.CNT_W(CW_A), .WINDOW(WIN), .ERR_LIMIT(LIM_A)) dut_a (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .clear_i   (clear),
        .valid_i   (valid),
        .data_i    (data),
        .locked_o  (locked_a),
        .err_o     (err_a),
        .lost_o    (lost_a),
        .err_cnt_o (cnt_a)
`ifdef LFSR_CHECKER_BIT_CNT_EN
        ,
        .bit_cnt_o (bits_a)
`endif
    );

    lfsr_16bit_checker #(.CNT_W(CW_B), .WINDOW(WIN), .ERR_LIMIT(LIM_B)) dut_b (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .clear_i   (clear),
        .valid_i   (valid),
        .data_i    (data),
        .locked_o  (locked_b),
        .err_o     (err_b),
        .lost_o    (lost_b),
        .err_cnt_o (cnt_b)
`ifdef LFSR_CHECKER_BIT_CNT_EN
        ,
        .bit_cnt_o (bits_b)
`endif
    );

    // Reference model: received-bit history plus per-instance lock/window bookkeeping.
    int     lim[2]  = '{LIM_A, LIM_B};
    int     cmax[2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};
    bit     m_locked[2];
    int     m_fill[2], m_wb[2], m_we[2], m_cnt[2];
    longint m_bits[2];
    bit     e_err[2], e_lost[2];
    bit     hist[$];
    logic [15:0] g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=0x%0h exp=0x%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit bit_ago(input int k);
        return (hist.size() >= k) ? hist[hist.size() - k] : 1'b0;
    endfunction

    function automatic bit model_pred();
        return ~(bit_ago(16) ^ bit_ago(13) ^ bit_ago(6) ^ bit_ago(2));
    endfunction

    function automatic bit last16_ones();
        if (hist.size() < 16) return 1'b0;
        for (int k = 1; k <= 16; k++) if (!bit_ago(k)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_locked[i] = 0; m_fill[i] = 0; m_wb[i] = 0; m_we[i] = 0;
            m_cnt[i] = 0; m_bits[i] = 0; e_err[i] = 0; e_lost[i] = 0;
        end
        hist.delete();
    endtask

    task automatic model_step(input logic v, input logic d, input logic clr);
        bit p, mm;
        p = model_pred();
        for (int i = 0; i < 2; i++) begin
            mm = 0;
            e_err[i] = 0;
            e_lost[i] = 0;
            if (v && !m_locked[i]) begin
                m_fill[i]++;
            end else if (v) begin
                mm = (d != p);
                e_err[i] = mm;
                m_wb[i]++;
                m_we[i] += int'(mm);
                if (m_we[i] >= lim[i]) begin
                    m_locked[i] = 0; e_lost[i] = 1; m_fill[i] = 0; m_wb[i] = 0; m_we[i] = 0;
                end else if (m_wb[i] == WIN) begin
                    m_wb[i] = 0; m_we[i] = 0;
                end
                if (m_bits[i] < 64'hFFFF_FFFF) m_bits[i]++;
            end
            if (clr) begin
                m_cnt[i] = 0; m_wb[i] = 0; m_we[i] = 0; m_bits[i] = 0;
            end else if (mm && m_cnt[i] < cmax[i]) begin
                m_cnt[i]++;
            end
        end
        if (v) begin
            hist.push_back(d);
            if (hist.size() > 16) void'(hist.pop_front());
        end
        for (int i = 0; i < 2; i++) begin
            if (v && !m_locked[i] && m_fill[i] == 16) begin
                m_fill[i] = 0;
                if (!last16_ones()) m_locked[i] = 1;
            end
        end
    endtask

    task automatic compare_all();
        chk("locked_a", 32'(locked_a), 32'(m_locked[0]));
        chk("err_a",    32'(err_a),    32'(e_err[0]));
        chk("lost_a",   32'(lost_a),   32'(e_lost[0]));
        chk("cnt_a",    32'(cnt_a),    32'(m_cnt[0]));
        chk("locked_b", 32'(locked_b), 32'(m_locked[1]));
        chk("err_b",    32'(err_b),    32'(e_err[1]));
        chk("lost_b",   32'(lost_b),   32'(e_lost[1]));
        chk("cnt_b",    32'(cnt_b),    32'(m_cnt[1]));
`ifdef LFSR_CHECKER_BIT_CNT_EN
        chk("bits_a",   bits_a,        32'(m_bits[0]));
        chk("bits_b",   bits_b,        32'(m_bits[1]));
`endif
    endtask

    task automatic cycle(input logic v, input logic d, input logic clr);
        valid = v;
        data  = d;
        clear = clr;
        @(posedge clk);
        model_step(v, d, clr);
        #1;
        compare_all();
    endtask

    task automatic gen_next(output logic b);
        b = ~(g[15] ^ g[12] ^ g[5] ^ g[1]);
        g = {g[14:0], b};
    endtask

    // Reset asserted asynchronously in the middle of a cycle.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_ni = 1'b0;
        valid  = 1'b0;
        clear  = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        #2 rst_ni = 1'b1;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        logic b;
        int   n;

        model_reset();
        do_reset();

        // 1: clean stream from seed 0
        g = 16'h0000;
        for (int i = 0; i < 200; i++) begin
            gen_next(b);
            cycle(1'b1, b, 1'b0);
        end
        chk("t1_locked", 32'(locked_a), 32'd1);
        chk("t1_cnt", 32'(cnt_a), 32'd0);

        // 2: single flipped bit
        for (int i = 0; i < 120; i++) begin
            gen_next(b);
            if (i == 100) b = ~b;
            cycle(1'b1, b, 1'b0);
        end
        chk("t2_locked", 32'(locked_a), 32'd1);

        // 3: random bits until loss, then relock on the generator
        n = 0;
        while (m_locked[0] && n < 300) begin
            cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            n++;
        end
        chk("t3_lost", 32'(locked_a), 32'd0);
        for (int i = 0; i < 16; i++) begin
            gen_next(b);
            cycle(1'b1, b, 1'b0);
        end
        chk("t3_relock", 32'(locked_a), 32'd1);

        // 4: lock-up pattern must not lock
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 1'b0);
        chk("t4_no_lock_a", 32'(locked_a), 32'd0);
        chk("t4_no_lock_b", 32'(locked_b), 32'd0);
        g = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            gen_next(b);
            cycle(1'b1, b, 1'b0);
        end
        chk("t4_lock", 32'(locked_a), 32'd1);

        // 5: saturation of the 4-bit counter, then clear against a mismatch
        for (int i = 0; i < 20; i++) cycle(1'b1, ~model_pred(), 1'b0);
        chk("t5_sat", 32'(cnt_b), 32'hF);
        chk("t5_locked_b", 32'(locked_b), 32'd1);
        cycle(1'b1, ~model_pred(), 1'b1);
        chk("t5_clr_cnt", 32'(cnt_b), 32'd0);
        chk("t5_clr_err", 32'(err_b), 32'd1);

        // 6: gapped stream with a reset in the middle
        do_reset();
        g = 16'h0000;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset();
                g = 16'h0000;
            end
            if ($urandom_range(0, 1) == 1) begin
                gen_next(b);
                cycle(1'b1, b, 1'b0);
            end else begin
                cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
        end
        chk("t6_locked", 32'(locked_a), 32'd1);
        chk("t6_cnt", 32'(cnt_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "bench did not finish");
    end

endmodule
